// File: rtl/mealy_det_pkg.sv
// Shared definitions for the Mealy pattern detector: FSM state encodings and a
// constant clog2 used for sizing the fill counter.
package mealy_det_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'b00,
    ARMED = 2'b01
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mealy_det_counter.sv
// Match counter: count_q advances one cycle after inc; no backpressure.
// Wraps modulo 2^CNT_W unless MEALY_PATTERN_DETECTOR_CNT_SAT_EN selects saturation.
module mealy_det_counter
  import mealy_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
`ifdef MEALY_PATTERN_DETECTOR_CNT_SAT_EN
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + CNT_W'(1);
`else
    if (inc) count_d = count_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mealy_pattern_detector.sv
// Serial Mealy pattern detector: y_out is combinational with the completing bit,
// state/count update on the next edge; no backpressure. Optional MEALY_PATTERN_DETECTOR_CNT_SAT_EN.
module mealy_pattern_detector
  import mealy_det_pkg::*;
#(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1101,
  parameter int               CNT_W     = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      x_in,
  input  logic                      x_valid,
  input  logic                      pat_load,
  input  logic [PAT_W-1:0]          pattern_in,
  input  logic                      overlap,
  output logic                      y_out,
  output logic [1:0]                state,
  output logic [clog2(PAT_W)-1:0]   fill,
  output logic [CNT_W-1:0]          match_count
);

  localparam int                FILL_W   = clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  state_e            state_q, state_d;

  logic [PAT_W-1:0]  window;
  logic              accept;
  logic              match;

  assign window = {hist_q, x_in};
  assign accept = x_valid & ~pat_load & ~reset;
  assign match  = accept & (state_q == ARMED) & (window == pat_q);

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    if (pat_load) begin
      pat_d   = pattern_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else begin
      if (x_valid) hist_d = window[PAT_W-2:0];
      case (state_q)
        FILL: begin
          if (x_valid) begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_d == FILL_MAX) state_d = ARMED;
          end
        end
        ARMED: begin
          // Non-overlap restarts the fill; stale history is masked until re-armed.
          if (match && !overlap) begin
            state_d = FILL;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = FILL;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q   <= PAT_RESET;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  mealy_det_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock(clock),
    .reset(reset),
    .inc  (match),
    .count(match_count)
  );

  assign y_out = match;
  assign state = state_q;
  assign fill  = fill_q;

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Bench for mealy_pattern_detector: vector table, corner sequences and random
// stimulus against a queue-based model; second instance covers PAT_W=2 / CNT_W=2.
module tb_mealy_pattern_detector;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic       a_rst, a_v, a_x, a_ld, a_ov;
  logic [3:0] a_pin;
  logic       a_y;
  logic [1:0] a_st;
  logic [1:0] a_fill;
  logic [7:0] a_cnt;

  // Instance B: zero-detector size with a tiny counter
  logic       b_rst, b_v, b_x, b_ld, b_ov;
  logic [1:0] b_pin;
  logic       b_y;
  logic [1:0] b_st;
  logic [0:0] b_fill;
  logic [1:0] b_cnt;

  mealy_pattern_detector dut_a (
    .clock(clock), .reset(a_rst), .x_in(a_x), .x_valid(a_v), .pat_load(a_ld),
    .pattern_in(a_pin), .overlap(a_ov), .y_out(a_y), .state(a_st), .fill(a_fill),
    .match_count(a_cnt)
  );

  mealy_pattern_detector #(.PAT_W(2), .PAT_RESET(2'b10), .CNT_W(2)) dut_b (
    .clock(clock), .reset(b_rst), .x_in(b_x), .x_valid(b_v), .pat_load(b_ld),
    .pattern_in(b_pin), .overlap(b_ov), .y_out(b_y), .state(b_st), .fill(b_fill),
    .match_count(b_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted bits since the last clear (at most PAT_W-1 kept),
  // the current pattern and the match total.
  bit         q[$];
  logic [3:0] m_pat = 4'b1101;
  int         m_cnt = 0;

  task automatic a_cycle(input bit rst, input bit v, input bit x, input bit ld,
                         input logic [3:0] pin, input bit ov,
                         output logic oy, output logic [7:0] ocnt);
    bit         ey;
    logic [3:0] w;
    @(negedge clock);
    a_rst = rst; a_v = v; a_x = x; a_ld = ld; a_pin = pin; a_ov = ov;
    #1;
    ey = 1'b0;
    if (!rst && !ld && v && q.size() >= 3) begin
      w  = {q[0], q[1], q[2], x};
      ey = (w == m_pat);
    end
    chk("y_out", 32'(a_y), 32'(ey));
    oy = a_y;
    @(posedge clock);
    if (rst) begin
      q.delete(); m_pat = 4'b1101; m_cnt = 0;
    end else if (ld) begin
      q.delete(); m_pat = pin;
    end else if (v) begin
      if (ey) m_cnt = (m_cnt + 1) % 256;
      if (ey && !ov) q.delete();
      else begin
        q.push_back(x);
        if (q.size() > 3) void'(q.pop_front());
      end
    end
    #1;
    chk("state", 32'(a_st), (q.size() >= 3) ? 32'd1 : 32'd0);
    chk("fill", 32'(a_fill), (q.size() >= 3) ? 32'd3 : 32'(q.size()));
    chk("match_count", 32'(a_cnt), 32'(m_cnt));
    ocnt = a_cnt;
  endtask

  task automatic b_cycle(input bit rst, input bit v, input bit x, input bit ov,
                         output logic oy, output logic [1:0] ocnt);
    @(negedge clock);
    b_rst = rst; b_v = v; b_x = x; b_ld = 1'b0; b_pin = 2'b00; b_ov = ov;
    #1;
    oy = b_y;
    @(posedge clock);
    #1;
    ocnt = b_cnt;
  endtask

  typedef struct {
    bit         rst, v, x, ld;
    logic [3:0] pin;
    bit         ov;
    bit         ey;
    int         ecnt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit v, bit x, bit ov, bit ey, int ecnt);
    vec_t r;
    r.rst = rst; r.v = v; r.x = x; r.ld = 1'b0; r.pin = 4'b0000;
    r.ov = ov; r.ey = ey; r.ecnt = ecnt;
    return r;
  endfunction

  vec_t       tbl[$];
  logic       oy;
  logic [7:0] ocnt;
  logic [1:0] bcnt;
  int         exp_sat[5];

  initial begin
    a_rst = 1; a_v = 0; a_x = 0; a_ld = 0; a_pin = 0; a_ov = 1;
    b_rst = 1; b_v = 0; b_x = 0; b_ld = 0; b_pin = 0; b_ov = 1;

    // overlap: 1,1,(gap),0,1,1,0,1 -> hits on bits 4 and 7
    tbl.push_back(mk(1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 1, 2));
    // non-overlap: same stream -> only bit 4
    tbl.push_back(mk(1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 1));

    foreach (tbl[i]) begin
      a_cycle(tbl[i].rst, tbl[i].v, tbl[i].x, tbl[i].ld, tbl[i].pin, tbl[i].ov, oy, ocnt);
      chk($sformatf("tbl_y[%0d]", i), 32'(oy), 32'(tbl[i].ey));
      chk($sformatf("tbl_cnt[%0d]", i), 32'(ocnt), 32'(tbl[i].ecnt));
    end

    // non-overlap: FSM back to FILL, fill 0 right after the match
    a_cycle(1, 0, 0, 0, 4'h0, 0, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 0, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 0, oy, ocnt);
    a_cycle(0, 1, 0, 0, 4'h0, 0, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 0, oy, ocnt);
    chk("nov_hit", 32'(oy), 32'd1);
    chk("nov_state", 32'(a_st), 32'd0);
    chk("nov_fill", 32'(a_fill), 32'd0);

    // load collides with a valid bit: sample dropped, new pattern 0110
    a_cycle(1, 0, 0, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 0, 1, 4'b0110, 1, oy, ocnt);
    chk("ld_y", 32'(oy), 32'd0);
    chk("ld_fill", 32'(a_fill), 32'd0);
    a_cycle(0, 1, 0, 0, 4'h0, 1, oy, ocnt); chk("ld_b1", 32'(oy), 32'd0);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt); chk("ld_b2", 32'(oy), 32'd0);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt); chk("ld_b3", 32'(oy), 32'd0);
    a_cycle(0, 1, 0, 0, 4'h0, 1, oy, ocnt); chk("ld_b4", 32'(oy), 32'd1);

    // reset mid-stream discards history
    a_cycle(1, 0, 0, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 0, 0, 4'h0, 1, oy, ocnt);
    a_cycle(1, 1, 1, 0, 4'h0, 1, oy, ocnt);
    chk("rst_y", 32'(oy), 32'd0);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt); chk("rst_b1", 32'(oy), 32'd0);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 0, 0, 4'h0, 1, oy, ocnt);
    a_cycle(0, 1, 1, 0, 4'h0, 1, oy, ocnt);
    chk("rst_hit", 32'(oy), 32'd1);
    chk("rst_cnt", 32'(ocnt), 32'd1);

    // random traffic, model checks every cycle
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      a_cycle(r == 0, $urandom_range(0, 3) != 0, 1'($urandom), (r > 0) && (r < 5),
              4'($urandom), 1'($urandom), oy, ocnt);
    end

    // PAT_W=2 zero detector with gaps: 1,_,1,_,0,_,0,1,_,0
    b_cycle(1, 0, 0, 1, oy, bcnt);
    chk("b_rst_cnt", 32'(bcnt), 32'd0);
    chk("b_rst_state", 32'(b_st), 32'd0);
    b_cycle(0, 1, 1, 1, oy, bcnt); chk("zd_b1", 32'(oy), 32'd0);
    b_cycle(0, 0, 0, 1, oy, bcnt); chk("zd_gap1", 32'(oy), 32'd0);
    b_cycle(0, 1, 1, 1, oy, bcnt); chk("zd_b2", 32'(oy), 32'd0);
    b_cycle(0, 0, 0, 1, oy, bcnt); chk("zd_gap2", 32'(oy), 32'd0);
    b_cycle(0, 1, 0, 1, oy, bcnt); chk("zd_b3", 32'(oy), 32'd1);
    b_cycle(0, 0, 0, 1, oy, bcnt); chk("zd_gap3", 32'(oy), 32'd0);
    b_cycle(0, 1, 0, 1, oy, bcnt); chk("zd_b4", 32'(oy), 32'd0);
    b_cycle(0, 1, 1, 1, oy, bcnt); chk("zd_b5", 32'(oy), 32'd0);
    b_cycle(0, 0, 1, 1, oy, bcnt); chk("zd_gap4", 32'(oy), 32'd0);
    b_cycle(0, 1, 0, 1, oy, bcnt); chk("zd_b6", 32'(oy), 32'd1);
    chk("zd_cnt", 32'(bcnt), 32'd2);

    // 2-bit counter boundary: five matches of 10
`ifdef MEALY_PATTERN_DETECTOR_CNT_SAT_EN
    exp_sat = '{1, 2, 3, 3, 3};
`else
    exp_sat = '{1, 2, 3, 0, 1};
`endif
    b_cycle(1, 0, 0, 1, oy, bcnt);
    for (int k = 0; k < 5; k++) begin
      b_cycle(0, 1, 1, 1, oy, bcnt);
      b_cycle(0, 1, 0, 1, oy, bcnt);
      chk($sformatf("cnt_hit[%0d]", k), 32'(oy), 32'd1);
      chk($sformatf("cnt_val[%0d]", k), 32'(bcnt), 32'(exp_sat[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
